// File: rtl/image_pkg.sv
// rtl/image_pkg.sv - shared image geometry defaults, packer FSM encoding and frame-size helper
package image_pkg;

  localparam int IMG_WIDTH_DEF  = 720;
  localparam int IMG_HEIGHT_DEF = 540;

  typedef enum logic {
    S_FILL  = 1'b0,
    S_WRITE = 1'b1
  } pack_state_e;

  function automatic int frame_pixels(input int width, input int height);
    return width * height;
  endfunction

endpackage

// File: rtl/pixel_threshold.sv
// rtl/pixel_threshold.sv - binarizes one pixel: all-ones at or above THRESHOLD, zero below
module pixel_threshold #(
  parameter int DWIDTH_IN = 8,
  parameter int THRESHOLD = 128
) (
  input  logic [DWIDTH_IN-1:0] pix_i,
  output logic [DWIDTH_IN-1:0] pix_o
);

  localparam logic [DWIDTH_IN-1:0] THR = DWIDTH_IN'(THRESHOLD);

  assign pix_o = (pix_i >= THR) ? '1 : '0;

endmodule

// File: rtl/sobel_packer.sv
// rtl/sobel_packer.sv - packs sobel pixels into wide words with frame flush; SOBEL_PACK_THRESHOLD_EN binarizes pixels
module sobel_packer
  import image_pkg::*;
#(
  parameter int IMG_WIDTH    = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT   = IMG_HEIGHT_DEF,
  parameter int DWIDTH_IN    = 8,
  parameter int PIX_PER_WORD = 4,
  parameter int DWIDTH_OUT   = 32,
  parameter int THRESHOLD    = 128
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  in_rd_en,
  input  logic [DWIDTH_IN-1:0]  in_dout,
  input  logic                  in_empty,
  output logic                  out_wr_en,
  output logic [DWIDTH_OUT-1:0] out_din,
  input  logic                  out_full,
  output logic                  frame_done
);

  localparam int NPIX   = frame_pixels(IMG_WIDTH, IMG_HEIGHT);
  localparam int CNT_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int LANE_W = $clog2(PIX_PER_WORD);
  localparam logic [CNT_W-1:0]  LAST_PIX  = CNT_W'(NPIX - 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PIX_PER_WORD - 1);

  if (PIX_PER_WORD < 2 || DWIDTH_OUT != DWIDTH_IN * PIX_PER_WORD ||
      THRESHOLD >= 2 ** DWIDTH_IN) begin : g_bad_params
    $error("sobel_packer: inconsistent parameters");
  end

  pack_state_e           state_q, state_d;
  logic [LANE_W-1:0]     lane_cnt_q, lane_cnt_d;
  logic [CNT_W-1:0]      pix_cnt_q, pix_cnt_d;
  logic [DWIDTH_OUT-1:0] word_q, word_d;
  logic [DWIDTH_IN-1:0]  pix;
  logic                  pop, push;

`ifdef SOBEL_PACK_THRESHOLD_EN
  pixel_threshold #(
    .DWIDTH_IN (DWIDTH_IN),
    .THRESHOLD (THRESHOLD)
  ) u_threshold (
    .pix_i (in_dout),
    .pix_o (pix)
  );
`else
  assign pix = in_dout;
`endif

  assign pop        = reset && (state_q == S_FILL) && !in_empty;
  assign push       = reset && (state_q == S_WRITE) && !out_full;
  assign in_rd_en   = pop;
  assign out_wr_en  = push;
  assign out_din    = word_q;
  // pix_cnt parks on the last index until the final word leaves
  assign frame_done = push && (pix_cnt_q == LAST_PIX);

  always_comb begin
    state_d    = state_q;
    lane_cnt_d = lane_cnt_q;
    pix_cnt_d  = pix_cnt_q;
    word_d     = word_q;
    case (state_q)
      S_FILL: begin
        if (pop) begin
          for (int l = 0; l < PIX_PER_WORD; l++) begin
            if (lane_cnt_q == LANE_W'(l)) word_d[l*DWIDTH_IN +: DWIDTH_IN] = pix;
          end
          lane_cnt_d = lane_cnt_q + 1'b1;
          if (pix_cnt_q != LAST_PIX) pix_cnt_d = pix_cnt_q + 1'b1;
          if (lane_cnt_q == LAST_LANE || pix_cnt_q == LAST_PIX) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (push) begin
          state_d    = S_FILL;
          word_d     = '0;
          lane_cnt_d = '0;
          if (pix_cnt_q == LAST_PIX) pix_cnt_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_FILL;
      lane_cnt_q <= '0;
      pix_cnt_q  <= '0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      lane_cnt_q <= lane_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
      word_q     <= word_d;
    end
  end

endmodule

// File: tb/tb_sobel_packer.sv
// tb/tb_sobel_packer.sv - table-driven and randomized checks of sobel_packer on 8x4 and 5x3 frames
module tb_sobel_packer;

  localparam int DW     = 8;
  localparam int PPW    = 4;
  localparam int DWO    = DW * PPW;
  localparam int NPIX_A = 32;
  localparam int NPIX_B = 15;

`ifdef SOBEL_PACK_THRESHOLD_EN
  localparam logic [DWO-1:0] A_FIRST = 32'h0;
  localparam logic [DWO-1:0] A_LAST  = 32'h0;
  localparam logic [DWO-1:0] A_W2    = 32'h0;
  localparam logic [DWO-1:0] B_FIRST = 32'h0;
  localparam logic [DWO-1:0] B_LAST  = 32'h0;
  localparam logic [DWO-1:0] R_FIRST = 32'h0;
`else
  localparam logic [DWO-1:0] A_FIRST = 32'h03020100;
  localparam logic [DWO-1:0] A_LAST  = 32'h1F1E1D1C;
  localparam logic [DWO-1:0] A_W2    = 32'h0B0A0908;
  localparam logic [DWO-1:0] B_FIRST = 32'h04030201;
  localparam logic [DWO-1:0] B_LAST  = 32'h000F0E0D;
  localparam logic [DWO-1:0] R_FIRST = 32'h67666564;
`endif

  typedef struct {
    bit             sel;
    int             frames;
    int             base;
    int             empty_mode;
    int             full_mode;
    int             exp_words;
    logic [DWO-1:0] exp_first;
    logic [DWO-1:0] exp_last;
  } vec_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset;
  logic          sel;
  logic [DW-1:0] dout_v;
  logic          empty_v, full_v;

  logic           rd_a, wr_a, fd_a, rd_b, wr_b, fd_b;
  logic [DWO-1:0] din_a, din_b;
  logic           rd, wr, fd;
  logic [DWO-1:0] din;

  assign rd  = sel ? rd_b  : rd_a;
  assign wr  = sel ? wr_b  : wr_a;
  assign fd  = sel ? fd_b  : fd_a;
  assign din = sel ? din_b : din_a;

  sobel_packer #(
    .IMG_WIDTH(8), .IMG_HEIGHT(4), .DWIDTH_IN(DW), .PIX_PER_WORD(PPW),
    .DWIDTH_OUT(DWO), .THRESHOLD(128)
  ) dut_a (
    .clock(clock), .reset(reset), .in_rd_en(rd_a), .in_dout(dout_v),
    .in_empty(empty_v | sel), .out_wr_en(wr_a), .out_din(din_a),
    .out_full(full_v | sel), .frame_done(fd_a)
  );

  sobel_packer #(
    .IMG_WIDTH(5), .IMG_HEIGHT(3), .DWIDTH_IN(DW), .PIX_PER_WORD(PPW),
    .DWIDTH_OUT(DWO), .THRESHOLD(128)
  ) dut_b (
    .clock(clock), .reset(reset), .in_rd_en(rd_b), .in_dout(dout_v),
    .in_empty(empty_v | !sel), .out_wr_en(wr_b), .out_din(din_b),
    .out_full(full_v | !sel), .frame_done(fd_b)
  );

  logic [DW-1:0]  src_q[$];
  logic [DWO-1:0] got_w[$], exp_w[$];
  logic           got_fd[$], exp_fd[$];
  int             popped;
  bit             overlap;
  int             vectors = 0;
  int             miscompares = 0;
  vec_t           tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DWO-1:0] got_word(input int i);
    return (i < got_w.size()) ? got_w[i] : 'x;
  endfunction

  // Reference: split the pixel stream into frames, frames into PPW-wide groups, zero-pad the tail.
  task automatic build_model(input int npix);
    logic [DWO-1:0] word;
    logic [DW-1:0]  p;
    int             lane, pos;
    exp_w.delete();
    exp_fd.delete();
    word = '0;
    lane = 0;
    pos  = 0;
    foreach (src_q[i]) begin
      p = src_q[i];
`ifdef SOBEL_PACK_THRESHOLD_EN
      p = (p >= 8'd128) ? 8'hFF : 8'h00;
`endif
      word = word | (DWO'(p) << (DW * lane));
      lane++;
      pos++;
      if (lane == PPW || pos == npix) begin
        exp_w.push_back(word);
        exp_fd.push_back(pos == npix);
        word = '0;
        lane = 0;
        if (pos == npix) pos = 0;
      end
    end
  endtask

  task automatic apply(input int cyc, input int empty_mode, input int full_mode, input int stall_left);
    bit gate;
    case (empty_mode)
      1:       gate = (cyc % 2) == 1;
      2:       gate = ($urandom_range(0, 2) == 0);
      default: gate = 1'b0;
    endcase
    empty_v = (src_q.size() == 0) || gate;
    dout_v  = (src_q.size() != 0) ? src_q[0] : DW'($urandom);
    case (full_mode)
      1:       full_v = (stall_left > 0);
      2:       full_v = ($urandom_range(0, 2) == 0);
      default: full_v = 1'b0;
    endcase
  endtask

  task automatic run(input int n_exp, input int empty_mode, input int full_mode);
    int cyc, stall_left, settle;
    bit stalled;
    cyc = 0;
    stall_left = 0;
    settle = 0;
    stalled = 1'b0;
    got_w.delete();
    got_fd.delete();
    popped = 0;
    overlap = 1'b0;
    apply(cyc, empty_mode, full_mode, stall_left);
    while (cyc < 3000 && settle < 8) begin
      @(negedge clock);
      if (rd && wr) overlap = 1'b1;
      if (rd) begin
        void'(src_q.pop_front());
        popped++;
      end
      if (wr) begin
        got_w.push_back(din);
        got_fd.push_back(fd);
      end
      if (stall_left > 0) begin
        check("stall_hold", {wr, din}, {1'b0, A_W2});
        stall_left--;
      end
      if (got_w.size() >= n_exp) settle++;
      @(posedge clock);
      #1;
      cyc++;
      if (full_mode == 1 && !stalled && popped == 12) begin
        stalled = 1'b1;
        stall_left = 5;
      end
      apply(cyc, empty_mode, full_mode, stall_left);
    end
  endtask

  task automatic score(input string name);
    check({name, "_no_overlap"}, overlap, 1'b0);
    check({name, "_word_count"}, got_w.size(), exp_w.size());
    foreach (exp_w[i]) begin
      check($sformatf("%s_word%0d", name, i),
            {(i < got_fd.size()) ? got_fd[i] : 1'bx, got_word(i)},
            {exp_fd[i], exp_w[i]});
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int npix;
    tbl[0] = '{1'b0, 1,  0, 0, 0, 8,  A_FIRST, A_LAST};
    tbl[1] = '{1'b1, 1,  1, 0, 0, 4,  B_FIRST, B_LAST};
    tbl[2] = '{1'b0, 1,  0, 0, 1, 8,  A_FIRST, A_LAST};
    tbl[3] = '{1'b0, 1,  0, 1, 0, 8,  A_FIRST, A_LAST};
    tbl[4] = '{1'b0, 2, -1, 2, 2, 16, '0, '0};
    tbl[5] = '{1'b1, 3, -1, 2, 2, 12, '0, '0};

    reset   = 1'b0;
    sel     = 1'b0;
    empty_v = 1'b0;
    dout_v  = 8'h55;
    full_v  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_a", {rd_a, wr_a, fd_a, din_a}, '0);
    check("reset_b", {rd_b, wr_b, fd_b, din_b}, '0);
    reset = 1'b1;

    for (int t = 0; t < 6; t++) begin
      pulse_reset();
      sel  = tbl[t].sel;
      npix = tbl[t].sel ? NPIX_B : NPIX_A;
      src_q.delete();
      for (int i = 0; i < tbl[t].frames * npix; i++)
        src_q.push_back((tbl[t].base < 0) ? DW'($urandom) : DW'(tbl[t].base + i));
      build_model(npix);
      run(exp_w.size(), tbl[t].empty_mode, tbl[t].full_mode);
      score($sformatf("vec%0d", t));
      check($sformatf("vec%0d_table_words", t), got_w.size(), tbl[t].exp_words);
      if (tbl[t].base >= 0) begin
        check($sformatf("vec%0d_first", t), got_word(0), tbl[t].exp_first);
        check($sformatf("vec%0d_last", t), got_word(got_w.size() - 1), tbl[t].exp_last);
      end
    end

    pulse_reset();
    sel = 1'b0;
    src_q.delete();
    for (int i = 0; i < 6; i++) src_q.push_back(DW'(i));
    build_model(NPIX_A);
    run(exp_w.size(), 0, 0);
    score("pre_reset");
    check("pre_reset_pops", popped, 6);
    src_q.delete();
    for (int i = 0; i < NPIX_A; i++) src_q.push_back(DW'(100 + i));
    reset   = 1'b0;
    empty_v = 1'b0;
    dout_v  = src_q[0];
    full_v  = 1'b0;
    #2;
    check("mid_reset_outputs", {rd_a, wr_a, fd_a, din_a}, '0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    build_model(NPIX_A);
    run(exp_w.size(), 0, 0);
    score("post_reset");
    check("post_reset_first", got_word(0), R_FIRST);

`ifdef SOBEL_PACK_THRESHOLD_EN
    pulse_reset();
    sel = 1'b0;
    src_q.delete();
    src_q.push_back(8'd127);
    src_q.push_back(8'd128);
    src_q.push_back(8'd0);
    src_q.push_back(8'd255);
    build_model(NPIX_A);
    run(exp_w.size(), 0, 0);
    score("thresh");
    check("thresh_word", got_word(0), 32'hFF00FF00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
